alu_serial_ctrl: RTL and testbench

Bit-serial sequencer placed directly upstream of the alu_1bit cell. It accepts WIDTH-bit operands and a 2-bit opcode, then drives the 1-bit ALU LSB-first, one bit per clock. Between bits it holds the carry in a flop and shifts each alu_out bit into a result register. It gives a word-level NOT/OR/AND/ADD function using a single 1-bit datapath.

---
 rtl/alu_serial_ctrl.sv | 97 +++++++++
 tb/tb_alu_serial_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial word ALU sequencer. It drives a 1-bit ALU cell LSB-first, one
// bit per clock, and keeps the ripple carry in a flop between bits. Each
// returned bit is shifted into the result register from the top, so after
// WIDTH bits the word sits in its natural order.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [1:0]       alu_f,
  input  logic             alu_out,
  input  logic             alu_cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] OP_ADD = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh, res_q;
  logic [1:0]       op_q;
  logic             carry_q, cout_q;
  logic [CW-1:0]    cnt;
  logic             carry_nxt;

  // Only ADD propagates a carry; every other op keeps the carry at 0.
  assign carry_nxt = (op_q == OP_ADD) ? alu_cout : 1'b0;

  // Sequencer: accept in IDLE, process one bit per cycle in RUN, pulse in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res_q   <= '0;
      op_q    <= 2'b00;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            op_q    <= op;
            carry_q <= (op == OP_ADD) ? cin : 1'b0;
            cnt     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          res_q   <= {alu_out, res_q[WIDTH-1:1]};
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          cnt     <= cnt + CW'(1);
          carry_q <= carry_nxt;
          if (cnt == LAST) begin
            // Final carry is captured separately so it holds past DONE.
            cout_q <= carry_nxt;
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state == S_RUN);
  assign done    = (state == S_DONE);
  assign result  = res_q;
  assign cout    = cout_q;
  assign alu_a   = a_sh[0];
  assign alu_b   = b_sh[0];
  assign alu_cin = carry_q;
  assign alu_f   = op_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed and random checks of the bit-serial ALU sequencer, with a
// behavioural 1-bit ALU cell closing the loop on the alu_* ports.
module tb_alu_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] result;
  logic         alu_a, alu_b, alu_cin, alu_out, alu_cout;
  logic [1:0]   alu_f;

  int n_chk = 0, n_err = 0, n_done = 0, n_starts = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_f(alu_f),
    .alu_out(alu_out), .alu_cout(alu_cout)
  );

  // Combinational 1-bit ALU cell: 00 NOT a, 01 OR, 10 AND, 11 full add.
  assign alu_out  = (alu_f == 2'b00) ? ~alu_a :
                    (alu_f == 2'b01) ? (alu_a | alu_b) :
                    (alu_f == 2'b10) ? (alu_a & alu_b) :
                    (alu_a ^ alu_b ^ alu_cin);
  assign alu_cout = (alu_f == 2'b11) &
                    ((alu_a & alu_b) | (alu_a & alu_cin) | (alu_b & alu_cin));

  // Count every done pulse to compare against accepted starts.
  always @(negedge clk) if (done) n_done++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op at a negedge and follow it to completion. extra_at > 0
  // pulses a second (AND 0,0) start during RUN at that cycle number.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic xc, input logic [W-1:0] er,
                        input logic ec, input int extra_at);
    int k, nb;
    start = 1'b1; op = o; a = xa; b = xb; cin = xc;
    n_starts++;
    @(negedge clk);
    start = 1'b0;
    a = ~xa; b = ~xb; cin = ~xc; op = ~o;   // operands are free after acceptance
    k = 1; nb = 0;
    chk({tag, "_bit0_cin"}, 32'(alu_cin), 32'((o == 2'b11) ? xc : 1'b0));
    chk({tag, "_bit0_a"}, 32'(alu_a), 32'(xa[0]));
    while (!done && k < 40) begin
      if (busy) nb++;
      if (extra_at > 0 && k == extra_at) begin
        start = 1'b1; op = 2'b10; a = '0; b = '0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(k), 32'(W + 1));
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(W));
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    chk({tag, "_result_hold"}, 32'(result), 32'(er));
    chk({tag, "_cout_hold"}, 32'(cout), 32'(ec));
  endtask

  initial begin
    logic [W-1:0] ra, rb, er;
    logic [1:0]   ro;
    logic         rc, ec;
    logic [W:0]   s;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_alu", {27'd0, alu_a, alu_b, alu_cin, alu_f}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    run_op("add_a5_3c", 2'b11, 8'hA5, 8'h3C, 1'b0, 8'hE1, 1'b0, 0);
    run_op("add_ff_01", 2'b11, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 0);
    run_op("not_5a",    2'b00, 8'h5A, 8'hC3, 1'b1, 8'hA5, 1'b0, 0);
    run_op("or_0f_30",  2'b01, 8'h0F, 8'h30, 1'b1, 8'h3F, 1'b0, 0);
    run_op("and_f0_3c", 2'b10, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 0);
    run_op("ign_start", 2'b11, 8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 4);
    repeat (12) @(negedge clk);
    chk("ign_no_rerun", 32'(busy), 32'd0);
    chk("ign_done_count", 32'(n_done), 32'(n_starts));

    // Asynchronous reset in the middle of an ADD
    start = 1'b1; op = 2'b11; a = 8'hFF; b = 8'h01; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_carry", 32'(alu_cin), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst", 2'b11, 8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 0);

    // Random ops against a word-level model
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      ro = 2'($urandom_range(0, 3)); rc = 1'($urandom_range(0, 1));
      ec = 1'b0;
      case (ro)
        2'b00: er = ~ra;
        2'b01: er = ra | rb;
        2'b10: er = ra & rb;
        default: begin
          s  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
          er = s[W-1:0];
          ec = s[W];
        end
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, rc, er, ec, 0);
    end

    @(negedge clk);
    chk("done_count", 32'(n_done), 32'(n_starts));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
